// File: rtl/array_uart_pkg.sv
// Shared types and constants for the framed array UART receive path.
package array_uart_pkg;

   typedef enum logic [1:0] {HUNT, DATA, FOOTER} frame_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

   localparam logic [7:0] HEADER_BYTE = 8'hAA;
   localparam logic [7:0] FOOTER_BYTE = 8'h55;

   function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte deserialiser: 2-flop synchroniser, start-edge qualification, 8N1 sampling.
module uart_rx_byte
   import array_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       byte_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic             rx_p0, rx_p1, rx_p2;
   rx_state_t        state, state_d;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             fall, tick_half, tick_bit;

   assign fall      = rx_p2 & ~rx_p1;
   assign tick_half = (cnt == HALF_LAST);
   assign tick_bit  = (cnt == BIT_LAST);
   assign data      = shift;

   // synchroniser stage; rx_p2 only serves the falling-edge detector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
         rx_p2 <= 1'b1;
      end else begin
         rx_p0 <= uart_rx;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RX_IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         RX_IDLE:  if (fall) state_d = RX_START;
         RX_START: if (tick_half) state_d = rx_p1 ? RX_IDLE : RX_BITS;
         RX_BITS:  if (tick_bit && bit_idx == 3'd7) state_d = RX_STOP;
         RX_STOP:  if (tick_bit) state_d = RX_IDLE;
         default:  state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         bit_idx    <= '0;
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
         if (state == RX_IDLE || state_d != state || (state == RX_BITS && tick_bit))
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (state == RX_START)
            bit_idx <= '0;
         else if (state == RX_BITS && tick_bit)
            bit_idx <= bit_idx + 1'b1;
         if (state == RX_STOP && tick_bit) begin
            byte_valid <= rx_p1;
            byte_err   <= ~rx_p1;
         end
      end
   end

   // shift register holds its value from the last data bit through the stop sample
   always_ff @(posedge clk) begin
      if (state == RX_BITS && tick_bit)
         shift <= {rx_p1, shift[7:1]};
   end

endmodule

// File: rtl/array_uart_receiver.sv
// Framed array UART receiver: 0xAA header, NUM_WORDS LE words, 0x55 footer.
// Optional inter-byte timeout enabled by defining RX_TIMEOUT_EN.
module array_uart_receiver
   import array_uart_pkg::*;
#(
   parameter int CLOCK_FREQ   = 50_000_000,
   parameter int BAUD_RATE    = 115200,
   parameter int NUM_WORDS    = 1,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    uart_rx,
   output logic [32*NUM_WORDS-1:0] data_array,
   output logic                    frame_valid,
   output logic                    frame_error,
   output logic                    busy
);

   localparam int CLKS_PER_BIT     = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int TO_LIMIT         = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);

   logic [7:0]   byte_data;
   logic         byte_valid, byte_err;
   frame_state_t state, state_d;
   logic [3:0]   word_idx;
   logic [1:0]   byte_idx;
   logic         commit, abort, lane_wr, timeout;
   logic [NUM_WORDS-1:0][3:0][7:0] shadow;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx_byte (
      .clk        (clk),
      .rst        (rst),
      .uart_rx    (uart_rx),
      .data       (byte_data),
      .byte_valid (byte_valid),
      .byte_err   (byte_err)
   );

`ifdef RX_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_LIMIT + 1);
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             to_cnt <= '0;
      else if (state == HUNT || byte_valid) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + 1'b1;
   end

   assign timeout = (state != HUNT) && (to_cnt == TO_W'(TO_LIMIT));
`else
   // no counter: a frame in progress waits indefinitely for its next byte
   assign timeout = (TO_LIMIT < 0);
`endif

   assign busy = (state != HUNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= HUNT;
      else     state <= state_d;
   end

   // a received byte takes priority over a timeout expiring in the same cycle
   always_comb begin
      state_d = state;
      commit  = 1'b0;
      abort   = 1'b0;
      lane_wr = 1'b0;
      case (state)
         HUNT: begin
            if (byte_valid && byte_data == HEADER_BYTE) state_d = DATA;
         end
         DATA: begin
            if (byte_err) begin
               abort   = 1'b1;
               state_d = HUNT;
            end else if (byte_valid) begin
               lane_wr = 1'b1;
               if (byte_idx == 2'd3 && word_idx == LAST_WORD) state_d = FOOTER;
            end else if (timeout) begin
               abort   = 1'b1;
               state_d = HUNT;
            end
         end
         FOOTER: begin
            if (byte_err) begin
               abort   = 1'b1;
               state_d = HUNT;
            end else if (byte_valid) begin
               commit  = (byte_data == FOOTER_BYTE);
               abort   = (byte_data != FOOTER_BYTE);
               state_d = HUNT;
            end else if (timeout) begin
               abort   = 1'b1;
               state_d = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_idx    <= '0;
         byte_idx    <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         data_array  <= '0;
      end else begin
         frame_valid <= commit;
         frame_error <= abort;
         if (state == HUNT) begin
            word_idx <= '0;
            byte_idx <= '0;
         end else if (lane_wr) begin
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3 && word_idx != LAST_WORD) word_idx <= word_idx + 1'b1;
         end
         if (commit) data_array <= shadow;
      end
   end

   // shadow is fully rewritten by every frame before it can be committed
   always_ff @(posedge clk) begin
      if (lane_wr) begin
         for (int w = 0; w < NUM_WORDS; w++)
            if (word_idx == 4'(w)) shadow[w][byte_idx] <= byte_data;
      end
   end

endmodule

// File: tb/tb_array_uart_receiver.sv
// Directed bench: one NUM_WORDS=1 and one NUM_WORDS=2 receiver at 16 clocks per bit.
module tb_array_uart_receiver;

   localparam int CLK_FREQ = 160;
   localparam int BAUD     = 10;
   localparam int CPB      = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_a = 1'b1;
   logic        rx_b = 1'b1;
   logic [31:0] data_a;
   logic [63:0] data_b;
   logic        fv_a, fe_a, busy_a, fv_b, fe_b, busy_b;

   int checks = 0;
   int errors = 0;
   int nfv_a = 0, nfe_a = 0, nfv_b = 0, nfe_b = 0, both = 0;
   int fv0, fe0;
   logic [7:0] q [$];

   always #5 clk = ~clk;

   array_uart_receiver #(
      .CLOCK_FREQ (CLK_FREQ), .BAUD_RATE (BAUD), .NUM_WORDS (1), .TIMEOUT_BITS (20)
   ) u_dut_a (
      .clk (clk), .rst (rst), .uart_rx (rx_a), .data_array (data_a),
      .frame_valid (fv_a), .frame_error (fe_a), .busy (busy_a)
   );

   array_uart_receiver #(
      .CLOCK_FREQ (CLK_FREQ), .BAUD_RATE (BAUD), .NUM_WORDS (2), .TIMEOUT_BITS (20)
   ) u_dut_b (
      .clk (clk), .rst (rst), .uart_rx (rx_b), .data_array (data_b),
      .frame_valid (fv_b), .frame_error (fe_b), .busy (busy_b)
   );

   always @(negedge clk) begin
      if (fv_a) nfv_a++;
      if (fe_a) nfe_a++;
      if (fv_b) nfv_b++;
      if (fe_b) nfe_b++;
      if ((fv_a && fe_a) || (fv_b && fe_b)) both++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit to_b, input logic v);
      if (to_b) rx_b = v;
      else      rx_a = v;
   endtask

   task automatic send_byte(input bit to_b, input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(to_b, bits[i]);
         repeat (CPB) @(posedge clk);
      end
      drive(to_b, 1'b1);
   endtask

   task automatic send_seq(input bit to_b, input logic [7:0] s [$]);
      foreach (s[i]) send_byte(to_b, s[i], 1'b1);
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic glitch_a();
      @(posedge clk);
      #1 rx_a = 1'b0;
      @(posedge clk);
      #1 rx_a = 1'b1;
      repeat (2 * CPB) @(posedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_data_a", data_a, 0);
      check("rst_data_b", data_b, 0);
      check("rst_fv_fe", {fv_a, fe_a, fv_b, fe_b}, 0);
      check("rst_busy", {busy_a, busy_b}, 0);
      rst = 1'b0;
      repeat (2 * CPB) @(posedge clk);

      fv0 = nfv_a; fe0 = nfe_a;
      send_byte(1'b0, 8'hAA, 1'b1);
      #1 check("t1_busy_hdr", busy_a, 1);
      q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h55};
      send_seq(1'b0, q);
      settle();
      check("t1_data", data_a, 64'h12345678);
      check("t1_fv", nfv_a - fv0, 1);
      check("t1_fe", nfe_a - fe0, 0);
      check("t1_busy", busy_a, 0);

      fv0 = nfv_b; fe0 = nfe_b;
      q = '{8'h00, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55};
      send_seq(1'b1, q);
      settle();
      check("t2_data", data_b, 64'hDDCCBBAA_04030201);
      check("t2_fv", nfv_b - fv0, 1);
      check("t2_fe", nfe_b - fe0, 0);

      fv0 = nfv_a; fe0 = nfe_a;
      q = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      send_seq(1'b0, q);
      settle();
      check("t3_fe", nfe_a - fe0, 1);
      check("t3_fv", nfv_a - fv0, 0);
      check("t3_data_kept", data_a, 64'h12345678);
      check("t3_busy", busy_a, 0);

      fv0 = nfv_b; fe0 = nfe_b;
      send_byte(1'b1, 8'hAA, 1'b1);
      send_byte(1'b1, 8'h01, 1'b1);
      send_byte(1'b1, 8'h02, 1'b0);
      repeat (CPB) @(posedge clk);
      #1;
      check("t4_fe", nfe_b - fe0, 1);
      check("t4_busy", busy_b, 0);
      check("t4_data_kept", data_b, 64'hDDCCBBAA_04030201);
      q = '{8'hAA, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h55};
      send_seq(1'b1, q);
      settle();
      check("t4_data_good", data_b, 64'h80706050_40302010);
      check("t4_fv", nfv_b - fv0, 1);

      fv0 = nfv_a; fe0 = nfe_a;
      glitch_a();
      #1;
      check("t5_idle_pulses", (nfv_a - fv0) + (nfe_a - fe0), 0);
      check("t5_idle_busy", busy_a, 0);
      send_byte(1'b0, 8'hAA, 1'b1);
      glitch_a();
      q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h55};
      send_seq(1'b0, q);
      settle();
      check("t5_data", data_a, 64'hDEADBEEF);
      check("t5_fv", nfv_a - fv0, 1);
      check("t5_fe", nfe_a - fe0, 0);

      fv0 = nfv_a; fe0 = nfe_a;
      send_byte(1'b0, 8'hAA, 1'b1);
      send_byte(1'b0, 8'h11, 1'b1);
      repeat (18 * CPB) @(posedge clk);
      #1;
      check("t6_early_fe", nfe_a - fe0, 0);
      check("t6_early_busy", busy_a, 1);
      repeat (3 * CPB) @(posedge clk);
      #1;
`ifdef RX_TIMEOUT_EN
      check("t6_to_fe", nfe_a - fe0, 1);
      check("t6_to_busy", busy_a, 0);
      check("t6_to_data", data_a, 64'hDEADBEEF);
`else
      check("t6_wait_fe", nfe_a - fe0, 0);
      check("t6_wait_busy", busy_a, 1);
      q = '{8'h22, 8'h33, 8'h44, 8'h55};
      send_seq(1'b0, q);
      settle();
      check("t6_late_data", data_a, 64'h44332211);
      check("t6_late_fv", nfv_a - fv0, 1);
`endif

      check("never_both", both, 0);

      send_byte(1'b1, 8'hAA, 1'b1);
      send_byte(1'b1, 8'h01, 1'b1);
      #3 rst = 1'b1;
      #1;
      check("t8_data_b", data_b, 0);
      check("t8_data_a", data_a, 0);
      check("t8_busy", {busy_a, busy_b}, 0);
      check("t8_fv_fe", {fv_a, fe_a, fv_b, fe_b}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
